// File: rtl/siso_shift_reg.sv
// Serial-in serial-out delay line: the bit sampled on sin at edge n is driven on sout after edge n+DEPTH-1.
// Latency is DEPTH cycles. There is no backpressure: the register shifts on every clock edge while out of reset.
module siso_shift_reg #(
    parameter int unsigned DEPTH       = 4,
    parameter logic        RESET_VALUE = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic sin,
    output logic sout
);

    generate
        if (DEPTH < 1 || DEPTH > 64) begin : g_bad_depth
            $error("siso_shift_reg: DEPTH must be in 1..64");
        end
    endgenerate

    // q[0] is the input stage and q[DEPTH-1] is the output stage.
    logic [DEPTH-1:0] q;

    generate
        if (DEPTH == 1) begin : g_single
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    q <= RESET_VALUE;
                end else begin
                    q <= sin;
                end
            end
        end else begin : g_chain
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    q <= {DEPTH{RESET_VALUE}};
                end else begin
                    q <= {q[DEPTH-2:0], sin};
                end
            end
        end
    endgenerate

    assign sout = q[DEPTH-1];

endmodule

// File: tb/tb_siso_shift_reg.sv
// Bench that runs three delay depths side by side on a shared sin and rst.
// A queue model predicts each output bit into a scoreboard, and a separate monitor pops and compares every cycle.
module tb_siso_shift_reg;

    localparam logic RV = 1'b0;

    typedef struct packed {
        logic d1;
        logic d4;
        logic d8;
    } exp_t;

    logic clk;
    logic rst;
    logic sin;
    logic sout1, sout4, sout8;

    int checks = 0;
    int errors = 0;

    exp_t exp_q[$];
    logic m1[$];
    logic m4[$];
    logic m8[$];

    siso_shift_reg #(.DEPTH(1), .RESET_VALUE(RV)) u_d1 (.clk(clk), .rst(rst), .sin(sin), .sout(sout1));
    siso_shift_reg #(.DEPTH(4), .RESET_VALUE(RV)) u_d4 (.clk(clk), .rst(rst), .sin(sin), .sout(sout4));
    siso_shift_reg #(.DEPTH(8), .RESET_VALUE(RV)) u_d8 (.clk(clk), .rst(rst), .sin(sin), .sout(sout8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
        end
    endtask

    // Model: each depth is a FIFO that holds exactly DEPTH bits.
    task automatic model_reset();
        m1.delete(); m4.delete(); m8.delete();
        m1.push_back(RV);
        for (int i = 0; i < 4; i++) m4.push_back(RV);
        for (int i = 0; i < 8; i++) m8.push_back(RV);
    endtask

    task automatic model_step(input logic s);
        exp_t e;
        if (rst) begin
            m1.push_back(s); void'(m1.pop_front());
            m4.push_back(s); void'(m4.pop_front());
            m8.push_back(s); void'(m8.pop_front());
            e.d1 = m1[0];
            e.d4 = m4[0];
            e.d8 = m8[0];
        end else begin
            e = '{RV, RV, RV};
        end
        exp_q.push_back(e);
    endtask

    // Drive sin on the falling edge, then account for the following rising edge.
    task automatic cycle(input logic s);
        @(negedge clk);
        sin = s;
        @(posedge clk);
        model_step(s);
    endtask

    // Called right after a rising edge, so the reset moves mid-cycle.
    task automatic assert_rst(input string name);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check({name, "_async_d1"}, sout1, RV);
        check({name, "_async_d4"}, sout4, RV);
        check({name, "_async_d8"}, sout8, RV);
    endtask

    task automatic release_rst();
        #2;
        rst = 1'b1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sout_d1", sout1, e.d1);
                check("sout_d4", sout4, e.d4);
                check("sout_d8", sout8, e.d8);
            end
        end
    end

    initial begin : watchdog
        #400000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : stimulus
        rst = 1'b1;
        sin = 1'b1;
        @(posedge clk);
        @(posedge clk);

        // Reset with sin held high, then three edges while in reset.
        assert_rst("t1");
        repeat (3) cycle(1'b1);

        // Fill with ones.
        release_rst();
        repeat (4) cycle(1'b1);

        // Pattern 1,0,1,1 after a fresh reset.
        assert_rst("t3");
        cycle(1'b0);
        release_rst();
        cycle(1'b1); cycle(1'b0); cycle(1'b1); cycle(1'b1);
        repeat (8) cycle(1'b0);

        // Drain after a fill with ones.
        repeat (8) cycle(1'b1);
        repeat (9) cycle(1'b0);

        // Reset mid-stream, then sin=1 after release.
        repeat (8) cycle(1'b1);
        assert_rst("t5");
        cycle(1'b1);
        release_rst();
        repeat (9) cycle(1'b1);

        // Single-bit pulse.
        repeat (8) cycle(1'b0);
        cycle(1'b1);
        repeat (10) cycle(1'b0);

        // Random traffic with occasional mid-stream resets.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 39) == 0) begin
                assert_rst("rnd");
                repeat ($urandom_range(1, 3)) cycle(1'($urandom_range(0, 1)));
                release_rst();
            end
            cycle(1'($urandom_range(0, 1)));
        end

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
